xalu_ise_arb: RTL and testbench

XALU_ISE_ARB -- requirements
Module: xalu_ise_arb

---
 rtl/xalu_ise_arb.sv | 174 +++++++++++++++++
 tb/tb_xalu_ise_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xalu_ise_arb.sv
// ---------------------------------------------------------------------------
// xalu_ise_arb
// Two-requester arbiter in front of a single custom-instruction datapath.
// One operation is in flight at a time: IDLE accepts a request, ISSUE drives
// the datapath for exactly one cycle, RESP returns the result to the grantee.
//
// Configuration macro: ROMULUS_ISE_ARB_RR_EN
//   defined   -> round-robin arbitration when both requesters are valid
//   undefined -> fixed priority, PRI_REQ wins (no last-grant pointer)
//
// Ports
//   ise_clk, ise_rst        clock, synchronous active-low reset
//   rN_valid / rN_ready     request handshake for requester N (N=0,1)
//   rN_fn, rN_imm           opcode (bits [1:0] pick CUSTOM_0..3) and funct imm
//   rN_in1, rN_in2          source operands
//   rN_rsp_valid/ready      response handshake for requester N
//   rN_rsp_data, rN_rsp_err result, and flag for an opcode the datapath rejected
//   dp_fn/imm/in1/in2/val   operation driven to the datapath
//   dp_oval, dp_out         datapath decode-accept and result (combinational)
//   busy                    high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module xalu_ise_arb #(
  parameter logic PRI_REQ = 1'b0
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [5:0]  r0_fn,
  input  logic [6:0]  r0_imm,
  input  logic [31:0] r0_in1,
  input  logic [31:0] r0_in2,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_data,
  output logic        r0_rsp_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [5:0]  r1_fn,
  input  logic [6:0]  r1_imm,
  input  logic [31:0] r1_in1,
  input  logic [31:0] r1_in2,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_data,
  output logic        r1_rsp_err,
  output logic [5:0]  dp_fn,
  output logic [6:0]  dp_imm,
  output logic [31:0] dp_in1,
  output logic [31:0] dp_in2,
  output logic        dp_val,
  input  logic        dp_oval,
  input  logic [31:0] dp_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  logic   gnt;
  logic   sel;
  logic   accept;
  logic   rsp_take;

`ifdef ROMULUS_ISE_ARB_RR_EN
  // rr_seen stays low until the first acceptance after reset, so the very
  // first contested grant goes to PRI_REQ rather than away from it.
  logic   last_gnt;
  logic   rr_seen;
`endif

  // Arbitration: a lone valid requester always wins; a contest is settled by
  // fixed priority or, when enabled, by the requester not granted last.
  always_comb begin
    sel = PRI_REQ;
    if (r0_valid && !r1_valid) begin
      sel = 1'b0;
    end else if (r1_valid && !r0_valid) begin
      sel = 1'b1;
    end else begin
`ifdef ROMULUS_ISE_ARB_RR_EN
      if (rr_seen) begin
        sel = ~last_gnt;
      end
`endif
    end
  end

  // Ready is gated with reset so nothing looks accepted while reset is held.
  assign accept   = (state == IDLE) && ise_rst && (r0_valid || r1_valid);
  assign r0_ready = accept && !sel;
  assign r1_ready = accept && sel;
  assign rsp_take = gnt ? r1_rsp_ready : r0_rsp_ready;

  // The dp_* registers double as the issue register: loaded on acceptance,
  // presented during ISSUE, and cleared when leaving ISSUE.
  always_ff @(posedge ise_clk) begin
    if (!ise_rst) begin
      state        <= IDLE;
      gnt          <= PRI_REQ;
      dp_val       <= 1'b0;
      dp_fn        <= '0;
      dp_imm       <= '0;
      dp_in1       <= '0;
      dp_in2       <= '0;
      r0_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r0_rsp_err   <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_data  <= '0;
      r1_rsp_err   <= 1'b0;
      busy         <= 1'b0;
`ifdef ROMULUS_ISE_ARB_RR_EN
      last_gnt     <= PRI_REQ;
      rr_seen      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt    <= sel;
            dp_val <= 1'b1;
            dp_fn  <= sel ? r1_fn  : r0_fn;
            dp_imm <= sel ? r1_imm : r0_imm;
            dp_in1 <= sel ? r1_in1 : r0_in1;
            dp_in2 <= sel ? r1_in2 : r0_in2;
            busy   <= 1'b1;
            state  <= ISSUE;
`ifdef ROMULUS_ISE_ARB_RR_EN
            last_gnt <= sel;
            rr_seen  <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          dp_val <= 1'b0;
          dp_fn  <= '0;
          dp_imm <= '0;
          dp_in1 <= '0;
          dp_in2 <= '0;
          // A rejected opcode returns zero data with the error flag set.
          if (gnt) begin
            r1_rsp_valid <= 1'b1;
            r1_rsp_data  <= dp_oval ? dp_out : 32'd0;
            r1_rsp_err   <= ~dp_oval;
          end else begin
            r0_rsp_valid <= 1'b1;
            r0_rsp_data  <= dp_oval ? dp_out : 32'd0;
            r0_rsp_err   <= ~dp_oval;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            r0_rsp_valid <= 1'b0;
            r0_rsp_data  <= '0;
            r0_rsp_err   <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r1_rsp_data  <= '0;
            r1_rsp_err   <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// ---------------------------------------------------------------------------
// tb_xalu_ise_arb
// Self-checking bench for xalu_ise_arb. A behavioural datapath sits on the
// dp_* port: it rejects CUSTOM_3 (fn[1:0]==3) or any opcode when force_err
// is set, otherwise returns in1+in2+imm (or a fixed override value).
// Expected grants come from a grant-history queue, expected results from the
// datapath rule. Works with or without ROMULUS_ISE_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_xalu_ise_arb;

  localparam logic PRI = 1'b0;

  logic        ise_clk = 1'b0;
  logic        ise_rst;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [5:0]  r0_fn;
  logic [6:0]  r0_imm;
  logic [31:0] r0_in1, r0_in2, r0_rsp_data;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [5:0]  r1_fn;
  logic [6:0]  r1_imm;
  logic [31:0] r1_in1, r1_in2, r1_rsp_data;
  logic [5:0]  dp_fn;
  logic [6:0]  dp_imm;
  logic [31:0] dp_in1, dp_in2, dp_out;
  logic        dp_val, dp_oval, busy;

  logic        force_err, ovr_en;
  logic [31:0] ovr_val;

  int checks = 0;
  int errors = 0;
  logic grant_hist[$];

  typedef struct {
    logic        v0;
    logic        v1;
    logic [5:0]  fn;
    logic [6:0]  imm;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ferr;
    logic        ovr;
    logic        eg;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[6];

  xalu_ise_arb #(.PRI_REQ(PRI)) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_fn(r0_fn), .r0_imm(r0_imm),
    .r0_in1(r0_in1), .r0_in2(r0_in2), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_fn(r1_fn), .r1_imm(r1_imm),
    .r1_in1(r1_in1), .r1_in2(r1_in2), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .dp_fn(dp_fn), .dp_imm(dp_imm), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_val(dp_val), .dp_oval(dp_oval), .dp_out(dp_out), .busy(busy)
  );

  always #5 ise_clk = ~ise_clk;

  always_comb begin
    dp_oval = !force_err && (dp_fn[1:0] != 2'b11);
    dp_out  = ovr_en ? ovr_val : (dp_in1 + dp_in2 + {25'd0, dp_imm});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1);
    r0_valid = v0;
    r1_valid = v1;
    #1;
  endtask

  // {err, data} the datapath is expected to hand back for these fields.
  function automatic logic [32:0] dp_ref(input logic [5:0] fn, input logic [6:0] imm,
                                         input logic [31:0] a, input logic [31:0] b);
    if (force_err || fn[1:0] == 2'b11) return {1'b1, 32'd0};
    if (ovr_en) return {1'b0, ovr_val};
    return {1'b0, a + b + {25'd0, imm}};
  endfunction

  function automatic logic model_arb(input logic v0, input logic v1);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
`ifdef ROMULUS_ISE_ARB_RR_EN
    if (grant_hist.size() > 0) return ~grant_hist[$];
`endif
    return PRI;
  endfunction

  function automatic logic [32:0] exp_for(input logic g);
    if (g) return dp_ref(r1_fn, r1_imm, r1_in1, r1_in2);
    return dp_ref(r0_fn, r0_imm, r0_in1, r0_in2);
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, " r0_ready"}, 32'(r0_ready), 32'd0);
    checkOutput({tag, " r1_ready"}, 32'(r1_ready), 32'd0);
    checkOutput({tag, " rsp_valid"}, 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
    checkOutput({tag, " rsp_err"}, 32'({r0_rsp_err, r1_rsp_err}), 32'd0);
    checkOutput({tag, " r0_rsp_data"}, r0_rsp_data, 32'd0);
    checkOutput({tag, " r1_rsp_data"}, r1_rsp_data, 32'd0);
    checkOutput({tag, " dp_val"}, 32'(dp_val), 32'd0);
    checkOutput({tag, " dp_fn_imm"}, 32'({dp_fn, dp_imm}), 32'd0);
    checkOutput({tag, " dp_in1"}, dp_in1, 32'd0);
    checkOutput({tag, " dp_in2"}, dp_in2, 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    ise_rst = 1'b0;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    repeat (2) @(posedge ise_clk);
    #1;
    checkResetState("reset");
    ise_rst = 1'b1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    grant_hist.delete();
  endtask

  // One full operation starting in IDLE, ending back in IDLE.
  task automatic runTxn(input string tag, input logic v0, input logic v1, input bit hold,
                        input int delay, input bit early, input logic eg, input logic [32:0] er);
    logic [5:0]  efn;
    logic [6:0]  eimm;
    logic [31:0] ein1, ein2;
    efn  = eg ? r1_fn  : r0_fn;
    eimm = eg ? r1_imm : r0_imm;
    ein1 = eg ? r1_in1 : r0_in1;
    ein2 = eg ? r1_in2 : r0_in2;
    applyStimulus(v0, v1);
    checkOutput({tag, " idle r0_ready"}, 32'(r0_ready), 32'(!eg));
    checkOutput({tag, " idle r1_ready"}, 32'(r1_ready), 32'(eg));
    @(posedge ise_clk);
    #1;
    if (!hold) begin
      r0_valid = 1'b0;
      r1_valid = 1'b0;
    end
    if (early) begin
      r0_rsp_ready = 1'b1;
      r1_rsp_ready = 1'b1;
    end
    #1;
    checkOutput({tag, " issue dp_val"}, 32'(dp_val), 32'd1);
    checkOutput({tag, " issue dp_fn_imm"}, 32'({dp_fn, dp_imm}), 32'({efn, eimm}));
    checkOutput({tag, " issue dp_in1"}, dp_in1, ein1);
    checkOutput({tag, " issue dp_in2"}, dp_in2, ein2);
    checkOutput({tag, " issue busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " issue ready"}, 32'({r0_ready, r1_ready}), 32'd0);
    checkOutput({tag, " issue rsp_valid"}, 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
    @(posedge ise_clk);
    #1;
    r0_rsp_ready = 1'b0;
    r1_rsp_ready = 1'b0;
    for (int k = 0; k <= delay; k++) begin
      #1;
      checkOutput({tag, " resp rsp_valid"}, 32'({r1_rsp_valid, r0_rsp_valid}), eg ? 32'd2 : 32'd1);
      checkOutput({tag, " resp data"}, eg ? r1_rsp_data : r0_rsp_data, er[31:0]);
      checkOutput({tag, " resp err"}, 32'(eg ? r1_rsp_err : r0_rsp_err), 32'(er[32]));
      checkOutput({tag, " resp other data"}, eg ? r0_rsp_data : r1_rsp_data, 32'd0);
      checkOutput({tag, " resp busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " resp ready"}, 32'({r0_ready, r1_ready}), 32'd0);
      checkOutput({tag, " resp dp"}, 32'({dp_val, dp_fn, dp_imm}) | dp_in1 | dp_in2, 32'd0);
      if (k == delay) begin
        if (eg) r1_rsp_ready = 1'b1; else r0_rsp_ready = 1'b1;
      end else begin
        if (eg) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
      end
      @(posedge ise_clk);
      #1;
      r0_rsp_ready = 1'b0;
      r1_rsp_ready = 1'b0;
    end
    #1;
    checkOutput({tag, " done busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done rsp_valid"}, 32'({r0_rsp_valid, r1_rsp_valid}), 32'd0);
    grant_hist.push_back(eg);
  endtask

  task automatic setFields(input logic [5:0] fn0, input logic [6:0] imm0, input logic [31:0] a0,
                           input logic [31:0] b0, input logic [5:0] fn1, input logic [6:0] imm1,
                           input logic [31:0] a1, input logic [31:0] b1);
    r0_fn = fn0; r0_imm = imm0; r0_in1 = a0; r0_in2 = b0;
    r1_fn = fn1; r1_imm = imm1; r1_in1 = a1; r1_in2 = b1;
  endtask

  initial begin
    logic        g;
    logic [32:0] er;
    ise_rst = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    force_err = 1'b0; ovr_en = 1'b0; ovr_val = 32'hA5A5A5A5;
    setFields(6'd0, 7'd0, 32'd0, 32'd0, 6'd0, 7'd0, 32'd0, 32'd0);

    tbl[0] = '{1'b1, 1'b0, 6'b000010, 7'h00, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 6'b000001, 7'h05, 32'h7, 32'h9, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 6'b000001, 7'h03, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 32'h21, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 6'b000011, 7'h11, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 6'b000000, 7'h7F, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h7F, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 6'b100010, 7'h01, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h2345678A, 1'b0};

    @(posedge ise_clk);
    #1;
    doReset();

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      setFields(tbl[i].fn, tbl[i].imm, tbl[i].in1, tbl[i].in2,
                tbl[i].fn, tbl[i].imm, tbl[i].in1, tbl[i].in2);
      force_err = tbl[i].ferr;
      ovr_en = tbl[i].ovr;
      runTxn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, 1'b0, i % 3, 1'b1,
             tbl[i].eg, {tbl[i].ee, tbl[i].ed});
    end
    force_err = 1'b0;
    ovr_en = 1'b0;

    $display("[TB] contested grants from reset");
    doReset();
    setFields(6'd1, 7'd2, 32'd100, 32'd3, 6'd2, 7'd4, 32'd200, 32'd5);
    for (int i = 0; i < 4; i++) begin
`ifdef ROMULUS_ISE_ARB_RR_EN
      g = (i % 2 == 1);
`else
      g = 1'b0;
`endif
      runTxn($sformatf("both%0d", i), 1'b1, 1'b1, 1'b1, 0, 1'b0, g, exp_for(g));
    end
    runTxn("r0drop", 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, exp_for(1'b1));

    $display("[TB] held response");
    runTxn("hold5", 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b1, exp_for(1'b1));
    applyStimulus(1'b0, 1'b0);

    $display("[TB] reset during issue");
    applyStimulus(1'b1, 1'b0);
    @(posedge ise_clk);
    #1;
    checkOutput("abort issue dp_val", 32'(dp_val), 32'd1);
    ise_rst = 1'b0;
    @(posedge ise_clk);
    #1;
    checkResetState("abort");
    ise_rst = 1'b1;
    r0_valid = 1'b0;
    r0_rsp_ready = 1'b1;
    grant_hist.delete();
    for (int k = 0; k < 4; k++) begin
      @(posedge ise_clk);
      #1;
      checkOutput($sformatf("abort post%0d rsp", k), 32'({r0_rsp_valid, r1_rsp_valid, busy, dp_val}), 32'd0);
    end
    r0_rsp_ready = 1'b0;

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      logic [1:0] vp;
      vp = 2'($urandom_range(1, 3));
      setFields(6'($urandom), 7'($urandom), $urandom, $urandom,
                6'($urandom), 7'($urandom), $urandom, $urandom);
      force_err = ($urandom_range(0, 7) == 0);
      g = model_arb(vp[0], vp[1]);
      er = exp_for(g);
      runTxn($sformatf("rnd%0d", i), vp[0], vp[1], 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), g, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
